// File: rtl/npn4_tt_sweeper_if.sv
// Control/result bus and cell-side signals for npn4_tt_sweeper.
//   master : requester plus the cell under test (drives start, expected, y)
//   slave  : the sweeper itself (drives x and all result outputs)
//   start, expected       -> request a sweep and supply the expected truth table
//   x -> / <- y           -> minterm drive to the cell and its combinational output
//   busy, done            -> sweep in progress / one-cycle results-valid pulse
//   truth_table, match,
//   fail_index            -> captured table and comparison result
interface npn4_tt_sweeper_if;
  logic        start;
  logic [15:0] expected;
  logic [3:0]  x;
  logic        y;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic        match;
  logic [3:0]  fail_index;

  modport master (
    output start, expected, y,
    input  x, busy, done, truth_table, match, fail_index
  );

  modport slave (
    input  start, expected, y,
    output x, busy, done, truth_table, match, fail_index
  );
endinterface

// File: rtl/npn4_tt_sweeper.sv
// Sweeps all 16 minterms into a 4-input cell, captures its truth table and
// compares it against an expected NPN representative.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of npn4_tt_sweeper_if (start/expected in, x out,
//                y in, busy/done/truth_table/match/fail_index out)
//   SETTLE     : cycles each minterm is held before y is sampled (1..15)
module npn4_tt_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  npn4_tt_sweeper_if.slave        bus
);

  localparam int unsigned MW   = 4;
  localparam int unsigned TT_W = 16;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SWEEP  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  localparam logic [MW-1:0] HOLD_INIT = MW'(SETTLE);
  localparam logic [MW-1:0] M_LAST    = MW'(15);

  logic [1:0]      state_q,  state_d;
  logic [MW-1:0]   m_q,      m_d;
  logic [MW-1:0]   hold_q,   hold_d;
  logic [TT_W-1:0] exp_q,    exp_d;
  logic [MW-1:0]   x_q,      x_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic [TT_W-1:0] tt_q,     tt_d;
  logic            match_q,  match_d;
  logic [MW-1:0]   fidx_q,   fidx_d;

  logic [TT_W-1:0] diff_c;
  logic [MW-1:0]   first_diff_c;

  // Lowest mismatching minterm; iterating downward lets the lowest set bit win.
  always_comb begin
    diff_c       = tt_q ^ exp_q;
    first_diff_c = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (diff_c[i]) first_diff_c = MW'(i);
    end
  end

  // State and datapath register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      hold_q  <= '0;
      exp_q   <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      match_q <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hold_q  <= hold_d;
      exp_q   <= exp_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      match_q <= match_d;
      fidx_q  <= fidx_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hold_d  = hold_q;
    exp_d   = exp_q;
    x_d     = x_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tt_d    = tt_q;
    match_d = match_q;
    fidx_d  = fidx_q;

    case (state_q)
      IDLE: begin
        x_d = '0;
        if (bus.start) begin
          exp_d   = bus.expected;
          tt_d    = '0;
          m_d     = '0;
          hold_d  = HOLD_INIT;
          busy_d  = 1'b1;
          match_d = 1'b0;
          fidx_d  = '0;
          state_d = SWEEP;
        end
      end

      SWEEP: begin
        if (hold_q == MW'(1)) begin
          tt_d[m_q] = bus.y;
          if (m_q == M_LAST) begin
            x_d     = '0;
            hold_d  = '0;
            state_d = REPORT;
          end else begin
            m_d    = m_q + MW'(1);
            x_d    = m_q + MW'(1);
            hold_d = HOLD_INIT;
          end
        end else begin
          hold_d = hold_q - MW'(1);
        end
      end

      REPORT: begin
        match_d = (tt_q == exp_q);
        fidx_d  = first_diff_c;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.x           = x_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = tt_q;
  assign bus.match       = match_q;
  assign bus.fail_index  = fidx_q;

endmodule

// File: tb/tb_npn4_tt_sweeper.sv
module tb_npn4_tt_sweeper;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [15:0] cell1;
  logic [15:0] cell3;

  npn4_tt_sweeper_if bus1 ();
  npn4_tt_sweeper_if bus3 ();

  // Behavioural cells: output is the truth-table bit selected by x.
  assign bus1.y = cell1[bus1.x];
  assign bus3.y = cell3[bus3.x];

  npn4_tt_sweeper #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  npn4_tt_sweeper #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests++; if (bus1.x !== 4'h0)       begin fails++; $display("FAIL reset_x got %h want 0", bus1.x); end
    tests++; if (bus1.busy !== 1'b0)    begin fails++; $display("FAIL reset_busy got %b want 0", bus1.busy); end
    tests++; if (bus1.done !== 1'b0)    begin fails++; $display("FAIL reset_done got %b want 0", bus1.done); end
    tests++; if (bus1.truth_table !== 16'h0) begin fails++; $display("FAIL reset_tt got %h want 0", bus1.truth_table); end
    tests++; if (bus1.match !== 1'b0)   begin fails++; $display("FAIL reset_match got %b want 0", bus1.match); end
    tests++; if (bus1.fail_index !== 4'h0) begin fails++; $display("FAIL reset_fidx got %h want 0", bus1.fail_index); end
    tests++; if (bus3.busy !== 1'b0 || bus3.x !== 4'h0) begin fails++; $display("FAIL reset_dut3 busy %b x %h want 0 0", bus3.busy, bus3.x); end
  endtask

  task automatic test_match();
    cell1         = 16'h01ac;
    bus1.expected = 16'h01ac;
    bus1.start    = 1'b1;
    tick();                       // E0 accepted
    bus1.start    = 1'b0;
    bus1.expected = 16'h0000;     // must be ignored, value was latched
    tests++; if (bus1.x !== 4'h0 || bus1.busy !== 1'b1) begin fails++; $display("FAIL match_e0 x %h busy %b want 0 1", bus1.x, bus1.busy); end
    for (int m = 1; m < 16; m++) begin
      tick();
      tests++; if (bus1.x !== 4'(m)) begin fails++; $display("FAIL match_x_step got %h want %h", bus1.x, 4'(m)); end
    end
    tick();                       // E16: last sample
    tests++; if (bus1.x !== 4'h0 || bus1.done !== 1'b0 || bus1.busy !== 1'b1) begin fails++; $display("FAIL match_e16 x %h done %b busy %b want 0 0 1", bus1.x, bus1.done, bus1.busy); end
    tick();                       // E17: report
    tests++; if (bus1.done !== 1'b1)  begin fails++; $display("FAIL match_done got %b want 1", bus1.done); end
    tests++; if (bus1.busy !== 1'b0)  begin fails++; $display("FAIL match_busy got %b want 0", bus1.busy); end
    tests++; if (bus1.truth_table !== 16'h01ac) begin fails++; $display("FAIL match_tt got %h want 01ac", bus1.truth_table); end
    tests++; if (bus1.match !== 1'b1) begin fails++; $display("FAIL match_flag got %b want 1", bus1.match); end
    tests++; if (bus1.fail_index !== 4'h0) begin fails++; $display("FAIL match_fidx got %h want 0", bus1.fail_index); end
    tick();
    tests++; if (bus1.done !== 1'b0 || bus1.match !== 1'b1) begin fails++; $display("FAIL match_hold done %b match %b want 0 1", bus1.done, bus1.match); end
  endtask

  task automatic test_mismatch();
    logic [15:0] exps [2];
    logic [3:0]  fis  [2];
    int          n;
    exps[0] = 16'h01a8; fis[0] = 4'd2;
    exps[1] = 16'h81ac; fis[1] = 4'd15;
    cell1 = 16'h01ac;
    for (int v = 0; v < 2; v++) begin
      bus1.expected = exps[v];
      bus1.start    = 1'b1;
      tick();
      bus1.start    = 1'b0;
      n = 0;
      for (int k = 1; k <= 100; k++) begin
        tick();
        if (bus1.done === 1'b1) begin n = k; break; end
      end
      tests++; if (n != 17) begin fails++; $display("FAIL mismatch_latency got %0d want 17", n); end
      tests++; if (bus1.match !== 1'b0) begin fails++; $display("FAIL mismatch_match got %b want 0", bus1.match); end
      tests++; if (bus1.fail_index !== fis[v]) begin fails++; $display("FAIL mismatch_fidx got %0d want %0d", bus1.fail_index, fis[v]); end
      tests++; if (bus1.truth_table !== 16'h01ac) begin fails++; $display("FAIL mismatch_tt got %h want 01ac", bus1.truth_table); end
      tick();
    end
  endtask

  task automatic test_no_restart();
    int first_done;
    int pulses;
    cell1         = 16'h01ac;
    bus1.expected = 16'h01ac;
    bus1.start    = 1'b1;
    tick();
    bus1.start    = 1'b0;
    first_done = 0;
    pulses     = 0;
    for (int k = 1; k <= 25; k++) begin
      bus1.start = (k == 5 || k == 10);
      tick();
      if (k == 5)  begin tests++; if (bus1.x !== 4'd5)  begin fails++; $display("FAIL norestart_x5 got %h want 5", bus1.x); end end
      if (k == 10) begin tests++; if (bus1.x !== 4'd10) begin fails++; $display("FAIL norestart_x10 got %h want a", bus1.x); end end
      if (bus1.done === 1'b1) begin
        pulses++;
        if (first_done == 0) first_done = k;
      end
    end
    bus1.start = 1'b0;
    tests++; if (first_done != 17) begin fails++; $display("FAIL norestart_latency got %0d want 17", first_done); end
    tests++; if (pulses != 1) begin fails++; $display("FAIL norestart_pulses got %0d want 1", pulses); end
    tests++; if (bus1.match !== 1'b1) begin fails++; $display("FAIL norestart_match got %b want 1", bus1.match); end
  endtask

  task automatic test_reset_mid();
    int n;
    cell1         = 16'h01ac;
    bus1.expected = 16'h01ac;
    bus1.start    = 1'b1;
    tick();
    bus1.start    = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    tests++; if (bus1.x !== 4'd7 || bus1.truth_table !== 16'h002c) begin fails++; $display("FAIL midreset_pre x %h tt %h want 7 002c", bus1.x, bus1.truth_table); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus1.x !== 4'h0 || bus1.busy !== 1'b0) begin fails++; $display("FAIL midreset_async x %h busy %b want 0 0", bus1.x, bus1.busy); end
    tests++; if (bus1.truth_table !== 16'h0 || bus1.match !== 1'b0) begin fails++; $display("FAIL midreset_async tt %h match %b want 0 0", bus1.truth_table, bus1.match); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (bus1.done !== 1'b0 || bus1.x !== 4'h0) begin fails++; $display("FAIL midreset_held done %b x %h want 0 0", bus1.done, bus1.x); end
    end
    rst_n = 1'b1;
    tick();
    tests++; if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin fails++; $display("FAIL midreset_release done %b busy %b want 0 0", bus1.done, bus1.busy); end
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (bus1.done === 1'b1) begin n = k; break; end
    end
    tests++; if (n != 17) begin fails++; $display("FAIL midreset_resweep_latency got %0d want 17", n); end
    tests++; if (bus1.truth_table !== 16'h01ac || bus1.match !== 1'b1) begin fails++; $display("FAIL midreset_resweep tt %h match %b want 01ac 1", bus1.truth_table, bus1.match); end
    tick();
  endtask

  task automatic test_settle3();
    int n;
    cell3         = 16'hffff;
    bus3.expected = 16'hffff;
    bus3.start    = 1'b1;
    tick();
    bus3.start    = 1'b0;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 2)  begin tests++; if (bus3.x !== 4'd0) begin fails++; $display("FAIL settle3_x_e2 got %h want 0", bus3.x); end end
      if (k == 3)  begin tests++; if (bus3.x !== 4'd1) begin fails++; $display("FAIL settle3_x_e3 got %h want 1", bus3.x); end end
      if (k == 5)  begin tests++; if (bus3.x !== 4'd1) begin fails++; $display("FAIL settle3_x_e5 got %h want 1", bus3.x); end end
      if (k == 6)  begin tests++; if (bus3.x !== 4'd2) begin fails++; $display("FAIL settle3_x_e6 got %h want 2", bus3.x); end end
      if (k == 47) begin tests++; if (bus3.x !== 4'd15) begin fails++; $display("FAIL settle3_x_e47 got %h want f", bus3.x); end end
      if (bus3.done === 1'b1) begin n = k; break; end
    end
    tests++; if (n != 49) begin fails++; $display("FAIL settle3_latency got %0d want 49", n); end
    tests++; if (bus3.truth_table !== 16'hffff) begin fails++; $display("FAIL settle3_tt got %h want ffff", bus3.truth_table); end
    tests++; if (bus3.match !== 1'b1 || bus3.fail_index !== 4'h0) begin fails++; $display("FAIL settle3_result match %b fidx %h want 1 0", bus3.match, bus3.fail_index); end
    tick();
  endtask

  task automatic test_back_to_back();
    int prev;
    int pulses;
    bit idle;
    cell1         = 16'h0000;
    bus1.expected = 16'h0000;
    bus1.start    = 1'b1;
    tick();
    prev   = 0;
    pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus1.done === 1'b1) begin
        pulses++;
        tests++; if (bus1.match !== 1'b1) begin fails++; $display("FAIL b2b_match got %b want 1", bus1.match); end
        tests++;
        if (prev == 0) begin
          if (k != 17) begin fails++; $display("FAIL b2b_first got %0d want 17", k); end
        end else begin
          if (k - prev != 18) begin fails++; $display("FAIL b2b_interval got %0d want 18", k - prev); end
        end
        prev = k;
      end
    end
    tests++; if (pulses != 3) begin fails++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
    bus1.start = 1'b0;
    idle = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus1.busy === 1'b0 && bus1.done === 1'b0) begin idle = 1'b1; break; end
    end
    tests++; if (!idle) begin fails++; $display("FAIL b2b_drain timeout busy %b", bus1.busy); end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    cell1         = 16'h0000;
    cell3         = 16'h0000;
    bus1.start    = 1'b0;
    bus1.expected = 16'h0000;
    bus3.start    = 1'b0;
    bus3.expected = 16'h0000;
    #12;
    test_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    test_match();
    test_mismatch();
    test_no_restart();
    test_reset_mid();
    test_settle3();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/npn4_tt_sweeper.md
# npn4_tt_sweeper

Sequential stimulus/capture stage wrapped around a 4-input single-output exact-synthesis cell (MIG/NPN netlist). On command it drives all 16 input minterms into the cell in order and samples the cell output for each one. It assembles the 16-bit truth table and compares it against an expected NPN representative. It lets the team verify each generated 4-input netlist in silicon/FPGA or in a shared testbench without per-function stimulus.

## Interface
Parameters:
- SETTLE, 1, cycles each minterm is held on `x` before `y` is sampled; legal range 1..15.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a sweep; sampled only in IDLE
- expected  in  16  expected truth table; bit m = f(minterm m); latched on accepted start
- x  out  4  drive to cell inputs; x[0]→x0 … x[3]→x3; registered
- y  in  1  cell output y0 (combinational from `x`)
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when results become valid
- truth_table  out  16  captured table; bit m = y sampled while x==m
- match  out  1  truth_table == latched expected; valid from done onward
- fail_index  out  4  lowest m with truth_table[m] != expected[m]; 0 when match

## Operation
- States: IDLE, SWEEP, REPORT.
- IDLE: x=0, busy=0. Results from the previous sweep are held. On an edge with start=1:
  - latch expected
  - clear truth_table
  - minterm counter m=0, x=0, hold counter=SETTLE
  - busy=1, match=0, fail_index=0
  - go to SWEEP.
- SWEEP: x=m. The hold counter decrements each edge. On the edge where it equals 1:
  - write truth_table[m] <= y
  - if m<15: m<=m+1, x<=m+1, reload hold counter=SETTLE
  - if m==15: go to REPORT, x<=0.
- REPORT: one cycle.
  - Compute match and fail_index from the completed table. fail_index is a priority encode of the XOR with expected, lowest bit first.
  - Assert done for this one cycle; busy<=0. Return to IDLE.
- start is ignored in SWEEP and REPORT; no queuing.
- expected input changes during a sweep have no effect.
- fail_index arithmetic is 4-bit unsigned; no wrap is possible because m saturates at 15.

## Timing
- Reset values (async assert, sync release): state=IDLE, x=0, busy=0, done=0, truth_table=0, match=0, fail_index=0, counters 0.
- Call the accepting edge E0.
- x=m is visible from E(m·SETTLE) to E((m+1)·SETTLE).
- y is sampled at edge E((m+1)·SETTLE).
- Last sample is taken at E(16·SETTLE).
- done, match, fail_index and the final truth_table are updated at E(16·SETTLE+1) and are visible in the following cycle.
- busy falls at that same edge.
- Start latency to done: 16·SETTLE+1 edges. With SETTLE=1 this is 17.
- Back-to-back operation: start may be high during the done cycle. It is accepted at the next edge (IDLE), giving a 1-cycle gap between sweeps.
- Reset mid-sweep:
  - all outputs return to reset values immediately
  - the partial table is discarded
  - no done pulse is produced.
- The cell is combinational, so `y` must be stable within SETTLE-1 cycles plus one clock period of the `x` change. SETTLE>1 is used only when the cell is retimed or registered.

## Test plan
- SETTLE=1, cell implements 0x01ac, expected=0x01ac, start at E0 → x steps 0..15 on E0..E15, done pulse after E17, truth_table=0x01ac, match=1, fail_index=0.
- Same cell, expected=0x01a8 → match=0, fail_index=2, truth_table=0x01ac.
- Pulse start again at E5 and E10 of a running sweep → no restart, done after E17 only, one pulse.
- Assert rst_n=0 while x==7 → x, busy, truth_table, match immediately 0; no done. Release, start → full correct sweep.
- SETTLE=3, cell tied y=1, expected=0xffff → each x value held 3 cycles, done after E49, truth_table=0xffff, match=1.
- start held high continuously, expected=0x0000, y=0 → sweeps repeat with done every 18 cycles, match=1 each time.
